mips_run_ctrl: RTL and testbench

- Run-control sequencer that sits between the SoC and its host or debug side, and gates the mips_soc core.
- Drives the core's active-high reset and a clock-enable/stall line.
- Executes RUN, HALT, STEP-n and CLEAR commands over a valid/ready handshake.
- Stops the core on PC breakpoint, step exhaustion or cycle-timeout, and reports the halt cause plus an executed-cycle count.

---
 rtl/mips_dbg_pkg.sv | 29 ++
 rtl/mips_run_ctrl.sv | 131 +++++++++++++
 tb/tb_mips_run_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types for the mips_soc run-control sequencer: command opcodes,
// run states, halt causes and the default core-reset length.
package mips_dbg_pkg;

  localparam int unsigned RST_CYCLES_DEF = 5;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'd0,
    CMD_HALT  = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_CLEAR = 2'd3
  } dbg_cmd_t;

  typedef enum logic [1:0] {
    ST_RESET_CORE = 2'd0,
    ST_HALTED     = 2'd1,
    ST_RUNNING    = 2'd2,
    ST_STEPPING   = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_CMD       = 3'd1,
    CAUSE_BREAK     = 3'd2,
    CAUSE_STEP_DONE = 3'd3,
    CAUSE_TIMEOUT   = 3'd4
  } halt_cause_t;

endpackage

// File: rtl/mips_run_ctrl.sv
// Run-control sequencer gating the mips_soc core: reset, run, halt, step-n,
// breakpoint and cycle-timeout stops with cause and executed-cycle count.
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  pc_current,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [CNT_W-1:0] timeout_cycles,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [1:0]       run_state,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done
);

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  run_state_t       state_q;
  halt_cause_t      cause_q;
  logic [RW-1:0]    rst_cnt_q;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] step_left_q;
  logic             bp_skip_q;
  logic             done_q;

  logic running, bp_hit, to_hit, cmd_acc;
  dbg_cmd_t op;

  assign op      = dbg_cmd_t'(cmd_op);
  assign running = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
  assign bp_hit  = bp_en && (pc_current == bp_addr) && !bp_skip_q;
  assign to_hit  = (timeout_cycles != '0) && (cycle_count_q >= timeout_cycles);
  assign cpu_en  = running && !bp_hit && !to_hit;
  assign cmd_ready = (state_q != ST_RESET_CORE);
  assign cmd_acc = cmd_valid && cmd_ready;
  assign cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;

  assign cpu_rst     = (state_q == ST_RESET_CORE);
  assign run_state   = state_q;
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;

  // Later assignments in the case below override the default count/step updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET_CORE;
      cause_q       <= CAUSE_NONE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      step_left_q   <= '0;
      bp_skip_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      bp_skip_q <= 1'b0;
      if (cpu_en) cycle_count_q <= cycle_count_d;
      if (cpu_en && state_q == ST_STEPPING) step_left_q <= step_left_q - 1'b1;
      unique case (state_q)
        ST_RESET_CORE: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q   <= ST_HALTED;
            rst_cnt_q <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        ST_HALTED: begin
          if (cmd_acc) begin
            unique case (op)
              CMD_RUN: begin
                state_q   <= ST_RUNNING;
                bp_skip_q <= 1'b1;
              end
              CMD_STEP: begin
                state_q     <= ST_STEPPING;
                bp_skip_q   <= 1'b1;
                step_left_q <= (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
              end
              CMD_CLEAR: begin
                state_q       <= ST_RESET_CORE;
                rst_cnt_q     <= '0;
                cycle_count_q <= '0;
                cause_q       <= CAUSE_NONE;
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (cmd_acc && op == CMD_CLEAR) begin
            state_q       <= ST_RESET_CORE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            cause_q       <= CAUSE_NONE;
          end else if (to_hit) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_TIMEOUT;
            done_q  <= 1'b1;
          end else if (bp_hit) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_BREAK;
            done_q  <= 1'b1;
          end else if (state_q == ST_STEPPING && cpu_en && step_left_q == CNT_W'(1)) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_STEP_DONE;
            done_q  <= 1'b1;
          end else if (cmd_acc && op == CMD_HALT) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_CMD;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a tiny sequential-PC core model
// that resets on cpu_rst and advances by 4 on each cpu_en-high edge.
module tb_mips_run_ctrl;
  import mips_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_current;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] timeout_cycles = 32'd0;
  logic        cpu_rst;
  logic        cpu_en;
  logic [1:0]  run_state;
  logic [2:0]  halt_cause;
  logic [31:0] cycle_count;
  logic        done;

  int total = 0;
  int bad = 0;

  mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n), .pc_current(pc_current),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_addr(bp_addr), .timeout_cycles(timeout_cycles),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .run_state(run_state),
    .halt_cause(halt_cause), .cycle_count(cycle_count), .done(done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_current <= 32'd0;
    else if (cpu_rst) pc_current <= 32'd0;
    else if (cpu_en) pc_current <= pc_current + 32'd4;
  end

  task automatic issueCmd(input logic [1:0] op, input logic [31:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_arg = 32'd0;
  endtask

  task automatic countRstCycles(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_rst) n++;
      else break;
    end
  endtask

  // Runs until HALTED, reporting enabled cycles, done pulses and the last run cycle.
  task automatic waitHalted(input int budget, output int enCnt, output int doneCnt,
                            output bit expired, output logic lastEn, output logic [31:0] lastPc);
    enCnt = 0;
    doneCnt = 0;
    expired = 1'b1;
    lastEn = 1'b0;
    lastPc = 32'd0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
      if (run_state == 2'd1) begin
        expired = 1'b0;
        break;
      end
      if (cpu_en) enCnt++;
      lastEn = cpu_en;
      lastPc = pc_current;
    end
    @(negedge clk);
    if (done) doneCnt++;
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(posedge clk);
    #1;
    total++; if (run_state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", run_state); end
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_cpu_rst got=%b want=1", cpu_rst); end
    total++; if (cpu_en !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ctl got en=%b rdy=%b done=%b want 0/0/0", cpu_en, cmd_ready, done);
    end
    total++; if (halt_cause !== 3'd0 || cycle_count !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_status got cause=%0d cnt=%0d want 0/0", halt_cause, cycle_count);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    countRstCycles(n);
    total++; if (n !== 5) begin bad++; $display("[TB] FAIL reset_len got=%0d want=5", n); end
    total++; if (run_state !== 2'd1 || cpu_en !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_idle got st=%0d en=%b rdy=%b want 1/0/1", run_state, cpu_en, cmd_ready);
    end
    total++; if (done !== 1'b0 || cycle_count !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_nodone got done=%b cnt=%0d want 0/0", done, cycle_count);
    end
  endtask

  task automatic test_breakpoint;
    int en, dn;
    bit exp;
    logic le;
    logic [31:0] lp;
    bp_en = 1'b1;
    bp_addr = 32'h100;
    timeout_cycles = 32'd0;
    issueCmd(CMD_RUN, 32'd0);
    waitHalted(300, en, dn, exp, le, lp);
    total++; if (exp) begin bad++; $display("[TB] FAIL bp_wait got=expired want=halted"); end
    total++; if (halt_cause !== 3'd2) begin bad++; $display("[TB] FAIL bp_cause got=%0d want=2", halt_cause); end
    total++; if (cycle_count !== 32'd64 || en !== 64) begin
      bad++; $display("[TB] FAIL bp_count got cnt=%0d en=%0d want 64/64", cycle_count, en);
    end
    total++; if (dn !== 1) begin bad++; $display("[TB] FAIL bp_done got=%0d want=1", dn); end
    total++; if (lp !== 32'h100 || le !== 1'b0 || pc_current !== 32'h100) begin
      bad++; $display("[TB] FAIL bp_stop got lastpc=%h en=%b pc=%h want 100/0/100", lp, le, pc_current);
    end
  endtask

  task automatic test_resume_halt;
    issueCmd(CMD_RUN, 32'd0);
    repeat (9) @(posedge clk);
    issueCmd(CMD_HALT, 32'd0);
    @(negedge clk);
    total++; if (done !== 1'b1 || run_state !== 2'd1) begin
      bad++; $display("[TB] FAIL halt_entry got done=%b st=%0d want 1/1", done, run_state);
    end
    total++; if (halt_cause !== 3'd1) begin bad++; $display("[TB] FAIL halt_cause got=%0d want=1", halt_cause); end
    total++; if (cycle_count !== 32'd74 || pc_current !== 32'h128) begin
      bad++; $display("[TB] FAIL halt_count got cnt=%0d pc=%h want 74/128", cycle_count, pc_current);
    end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL halt_pulse got=%b want=0", done); end
  endtask

  task automatic test_step;
    int en, dn;
    bit exp;
    logic le;
    logic [31:0] lp;
    issueCmd(CMD_STEP, 32'd3);
    waitHalted(50, en, dn, exp, le, lp);
    total++; if (exp || en !== 3) begin bad++; $display("[TB] FAIL step3_en got en=%0d exp=%b want 3/0", en, exp); end
    total++; if (halt_cause !== 3'd3 || cycle_count !== 32'd77 || dn !== 1) begin
      bad++; $display("[TB] FAIL step3_stat got cause=%0d cnt=%0d done=%0d want 3/77/1", halt_cause, cycle_count, dn);
    end
    issueCmd(CMD_STEP, 32'd0);
    waitHalted(50, en, dn, exp, le, lp);
    total++; if (exp || en !== 1) begin bad++; $display("[TB] FAIL step0_en got en=%0d exp=%b want 1/0", en, exp); end
    total++; if (halt_cause !== 3'd3 || cycle_count !== 32'd78) begin
      bad++; $display("[TB] FAIL step0_stat got cause=%0d cnt=%0d want 3/78", halt_cause, cycle_count);
    end
  endtask

  task automatic test_timeout;
    int en, dn, n;
    bit exp;
    logic le;
    logic [31:0] lp;
    issueCmd(CMD_CLEAR, 32'd0);
    total++; if (run_state !== 2'd0 || cycle_count !== 32'd0 || halt_cause !== 3'd0) begin
      bad++; $display("[TB] FAIL clr_halted got st=%0d cnt=%0d cause=%0d want 0/0/0", run_state, cycle_count, halt_cause);
    end
    countRstCycles(n);
    total++; if (n !== 5) begin bad++; $display("[TB] FAIL clr_halted_len got=%0d want=5", n); end
    bp_addr = 32'h50;
    timeout_cycles = 32'd20;
    issueCmd(CMD_RUN, 32'd0);
    waitHalted(100, en, dn, exp, le, lp);
    total++; if (exp || halt_cause !== 3'd4) begin
      bad++; $display("[TB] FAIL to_cause got cause=%0d exp=%b want 4/0", halt_cause, exp);
    end
    total++; if (cycle_count !== 32'd20 || en !== 20 || lp !== 32'h50) begin
      bad++; $display("[TB] FAIL to_count got cnt=%0d en=%0d pc=%h want 20/20/50", cycle_count, en, lp);
    end
  endtask

  task automatic test_clear_and_async;
    int n;
    timeout_cycles = 32'd0;
    bp_en = 1'b0;
    issueCmd(CMD_RUN, 32'd0);
    repeat (5) @(posedge clk);
    issueCmd(CMD_CLEAR, 32'd0);
    total++; if (run_state !== 2'd0 || cpu_rst !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_run got st=%0d rst=%b rdy=%b want 0/1/0", run_state, cpu_rst, cmd_ready);
    end
    total++; if (cycle_count !== 32'd0 || halt_cause !== 3'd0) begin
      bad++; $display("[TB] FAIL clr_run_stat got cnt=%0d cause=%0d want 0/0", cycle_count, halt_cause);
    end
    countRstCycles(n);
    total++; if (n !== 5) begin bad++; $display("[TB] FAIL clr_run_len got=%0d want=5", n); end
    issueCmd(CMD_STEP, 32'd1000);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (run_state !== 2'd0 || cpu_rst !== 1'b1 || cpu_en !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL async_ctl got st=%0d rst=%b en=%b rdy=%b want 0/1/0/0", run_state, cpu_rst, cpu_en, cmd_ready);
    end
    total++; if (cycle_count !== 32'd0 || halt_cause !== 3'd0 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL async_stat got cnt=%0d cause=%0d done=%b want 0/0/0", cycle_count, halt_cause, done);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    countRstCycles(n);
    total++; if (n !== 5 || run_state !== 2'd1) begin
      bad++; $display("[TB] FAIL async_len got n=%0d st=%0d want 5/1", n, run_state);
    end
  endtask

  initial begin
    test_reset();
    test_breakpoint();
    test_resume_halt();
    test_step();
    test_timeout();
    test_clear_and_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
